// File: rtl/ifetch_if.sv
// Instruction-memory read port between the fetch stage (master) and memory (slave).
// One request outstanding at a time; address held stable until ack.
interface ifetch_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned WORD_W = 32
);
  logic              imem_req_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_ack_i;
  logic [WORD_W-1:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch stage: single-outstanding memory request, one-entry skid buffer
// behind a registered output slot, and branch redirect with discard of in-flight reads.
module ifetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       WORD_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 1
) (
  input  logic              clk,
  input  logic              rst,
  ifetch_if.master          imem,
  input  logic              br_v_i,
  input  logic [ADDR_W-1:0] br_addr_i,
  input  logic              stall_i,
  output logic              v_o,
  output logic [WORD_W-1:0] inst_o,
  output logic [ADDR_W-1:0] origaddr_o
);

  typedef enum logic [1:0] {
    StFetch,
    StBlocked,
    StFlush
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              v_q;
  logic [WORD_W-1:0] inst_q;
  logic [ADDR_W-1:0] oaddr_q;
  logic [WORD_W-1:0] skid_inst_q;
  logic [ADDR_W-1:0] skid_addr_q;
  logic [ADDR_W-1:0] pc_next;

  // Modulo 2^ADDR_W: the add simply wraps.
  assign pc_next = pc_q + ADDR_W'(PC_STEP);

  // Skid occupancy is implied by StBlocked, so leaving that state empties it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      v_q         <= 1'b0;
      inst_q      <= '0;
      oaddr_q     <= '0;
      skid_inst_q <= '0;
      skid_addr_q <= '0;
    end else if (br_v_i) begin
      v_q  <= 1'b0;
      pc_q <= br_addr_i;
      unique case (state_q)
        StFetch:   state_q <= imem.imem_ack_i ? StFetch : StFlush;
        StFlush:   state_q <= imem.imem_ack_i ? StFetch : StFlush;
        StBlocked: state_q <= StFetch;
        default:   state_q <= StFetch;
      endcase
    end else begin
      unique case (state_q)
        StFetch: begin
          if (imem.imem_ack_i) begin
            pc_q <= pc_next;
            if (!v_q || !stall_i) begin
              inst_q  <= imem.imem_rdata_i;
              oaddr_q <= pc_q;
              v_q     <= 1'b1;
            end else begin
              skid_inst_q <= imem.imem_rdata_i;
              skid_addr_q <= pc_q;
              state_q     <= StBlocked;
            end
          end else if (v_q && !stall_i) begin
            v_q <= 1'b0;
          end
        end
        StBlocked: begin
          if (!stall_i) begin
            inst_q  <= skid_inst_q;
            oaddr_q <= skid_addr_q;
            v_q     <= 1'b1;
            state_q <= StFetch;
          end
        end
        StFlush: begin
          if (v_q && !stall_i) begin
            v_q <= 1'b0;
          end
          if (imem.imem_ack_i) begin
            state_q <= StFetch;
          end
        end
        default: state_q <= StFetch;
      endcase
    end
  end

  // Request is a pure function of state; gated by rst so it is low throughout reset.
  assign imem.imem_req_o  = rst && (state_q == StFetch);
  assign imem.imem_addr_o = pc_q;

  assign v_o        = v_q;
  assign inst_o     = inst_q;
  assign origaddr_o = oaddr_q;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: per-cycle vector table on a zero-wait memory, then
// hand-written wait-state flush and reset-while-blocked sequences.
module tb_ifetch;

  logic        clk;
  logic        rst;
  logic        br_v;
  logic [31:0] br_addr;
  logic        stall;
  logic        v;
  logic [31:0] inst;
  logic [31:0] origaddr;

  int          n_checks;
  int          n_fail;
  int unsigned mem_wait;

  ifetch_if #(.ADDR_W(32), .WORD_W(32)) bus ();

  ifetch #(
    .ADDR_W  (32),
    .WORD_W  (32),
    .RESET_PC(32'h0),
    .PC_STEP (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .imem      (bus.master),
    .br_v_i    (br_v),
    .br_addr_i (br_addr),
    .stall_i   (stall),
    .v_o       (v),
    .inst_o    (inst),
    .origaddr_o(origaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC3A5_5A3C;
  endfunction

  // Memory model: accepts a request, acks it mem_wait cycles later (same cycle if 0).
  logic        busy_q;
  int unsigned cnt_q;
  logic [31:0] maddr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q  <= 1'b0;
      cnt_q   <= 0;
      maddr_q <= '0;
    end else if (busy_q) begin
      if (cnt_q == 0) busy_q <= 1'b0;
      else            cnt_q  <= cnt_q - 1;
    end else if (bus.imem_req_o && mem_wait != 0) begin
      busy_q  <= 1'b1;
      cnt_q   <= mem_wait - 1;
      maddr_q <= bus.imem_addr_o;
    end
  end

  assign bus.imem_ack_i   = busy_q ? (cnt_q == 0) : (bus.imem_req_o && mem_wait == 0);
  assign bus.imem_rdata_i = mem_word(busy_q ? maddr_q : bus.imem_addr_o);

  typedef struct {
    logic        stall;
    logic        br_v;
    logic [31:0] br_addr;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_v;
    logic [31:0] exp_oa;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic b, input logic [31:0] ba,
                              input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] eo);
    vec_t r;
    r.stall = s; r.br_v = b; r.br_addr = ba;
    r.exp_req = er; r.exp_addr = ea; r.exp_v = ev; r.exp_oa = eo;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle: check request before the edge, output slot after it.
  task automatic run_vec(input vec_t t, input string tag);
    stall   = t.stall;
    br_v    = t.br_v;
    br_addr = t.br_addr;
    #1;
    check({tag, " req"}, 32'(bus.imem_req_o), 32'(t.exp_req));
    if (t.exp_req) check({tag, " addr"}, bus.imem_addr_o, t.exp_addr);
    @(posedge clk);
    #1;
    check({tag, " v"}, 32'(v), 32'(t.exp_v));
    if (t.exp_v) begin
      check({tag, " origaddr"}, origaddr, t.exp_oa);
      check({tag, " inst"}, inst, mem_word(t.exp_oa));
    end
  endtask

  vec_t vecs[23];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    mem_wait = 0;
    stall    = 1'b0;
    br_v     = 1'b0;
    br_addr  = '0;
    rst      = 1'b1;

    // Streaming, stall with skid, branch-with-ack, wrap, branch out of BLOCKED.
    vecs[0]  = mk(0, 0, 0,            1, 32'h0,        1, 32'h0);
    vecs[1]  = mk(0, 0, 0,            1, 32'h1,        1, 32'h1);
    vecs[2]  = mk(0, 0, 0,            1, 32'h2,        1, 32'h2);
    vecs[3]  = mk(0, 0, 0,            1, 32'h3,        1, 32'h3);
    vecs[4]  = mk(0, 0, 0,            1, 32'h4,        1, 32'h4);
    vecs[5]  = mk(0, 0, 0,            1, 32'h5,        1, 32'h5);
    vecs[6]  = mk(1, 0, 0,            1, 32'h6,        1, 32'h5);
    vecs[7]  = mk(1, 0, 0,            0, 32'h0,        1, 32'h5);
    vecs[8]  = mk(1, 0, 0,            0, 32'h0,        1, 32'h5);
    vecs[9]  = mk(0, 0, 0,            0, 32'h0,        1, 32'h6);
    vecs[10] = mk(0, 0, 0,            1, 32'h7,        1, 32'h7);
    vecs[11] = mk(0, 1, 32'h40,       1, 32'h8,        0, 32'h0);
    vecs[12] = mk(0, 0, 0,            1, 32'h40,       1, 32'h40);
    vecs[13] = mk(0, 0, 0,            1, 32'h41,       1, 32'h41);
    vecs[14] = mk(0, 1, 32'hFFFFFFFF, 1, 32'h42,       0, 32'h0);
    vecs[15] = mk(0, 0, 0,            1, 32'hFFFFFFFF, 1, 32'hFFFFFFFF);
    vecs[16] = mk(0, 0, 0,            1, 32'h0,        1, 32'h0);
    vecs[17] = mk(1, 0, 0,            1, 32'h1,        1, 32'h0);
    vecs[18] = mk(1, 1, 32'h10,       0, 32'h0,        0, 32'h0);
    vecs[19] = mk(1, 0, 0,            1, 32'h10,       1, 32'h10);
    vecs[20] = mk(1, 0, 0,            1, 32'h11,       1, 32'h10);
    vecs[21] = mk(0, 0, 0,            0, 32'h0,        1, 32'h11);
    vecs[22] = mk(0, 0, 0,            1, 32'h12,       1, 32'h12);

    // Power-on reset.
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset v", 32'(v), 32'h0);
    check("reset inst", inst, 32'h0);
    check("reset origaddr", origaddr, 32'h0);
    check("reset req", 32'(bus.imem_req_o), 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 23; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // 3-wait memory: idle slot drains, then branch to 0x80 while a read is in flight.
    mem_wait = 3;
    run_vec(mk(0, 0, 0,      1, 32'h13, 0, 32'h0), "drain");
    run_vec(mk(0, 1, 32'h80, 1, 32'h13, 0, 32'h0), "flush br");
    run_vec(mk(0, 0, 0,      0, 32'h0,  0, 32'h0), "flush wait");
    run_vec(mk(0, 0, 0,      0, 32'h0,  0, 32'h0), "flush discard");
    run_vec(mk(0, 0, 0,      1, 32'h80, 0, 32'h0), "refetch0");
    run_vec(mk(0, 0, 0,      1, 32'h80, 0, 32'h0), "refetch1");
    run_vec(mk(0, 0, 0,      1, 32'h80, 0, 32'h0), "refetch2");
    run_vec(mk(0, 0, 0,      1, 32'h80, 1, 32'h80), "refetch ack");

    // Reset while the skid is full and decode is stalled.
    mem_wait = 0;
    run_vec(mk(0, 0, 0, 1, 32'h81, 1, 32'h81), "pre-rst0");
    run_vec(mk(1, 0, 0, 1, 32'h82, 1, 32'h81), "pre-rst skid");
    run_vec(mk(1, 0, 0, 0, 32'h0,  1, 32'h81), "pre-rst blocked");
    #2 rst = 1'b0;
    #1;
    check("midrst v", 32'(v), 32'h0);
    check("midrst inst", inst, 32'h0);
    check("midrst origaddr", origaddr, 32'h0);
    check("midrst req", 32'(bus.imem_req_o), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_vec(mk(0, 0, 0, 1, 32'h0, 1, 32'h0), "post-rst");
    run_vec(mk(0, 0, 0, 1, 32'h1, 1, 32'h1), "post-rst next");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
